// File: rtl/row_conf_ctrl.sv
// Row configuration controller: shadow/active config banks for one PE row
// plus the IDLE/SWAP/RUN/DONE sequencer that commits and runs them.
module row_conf_ctrl #(
  parameter int PE_NUM     = 12,
  parameter int CONF_ALU_W = 4,
  parameter int CONF_SEL_W = 3,
  parameter int CONF_SE_W  = 3,
  parameter int LEN_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [3:0]                     cfg_pe,
  input  logic [1:0]                     cfg_field,
  input  logic [3:0]                     cfg_data,
  input  logic                           start,
  input  logic [LEN_W-1:0]               run_len,
  input  logic                           abort,
  output logic [PE_NUM*CONF_ALU_W-1:0]   conf_alu,
  output logic [PE_NUM*CONF_SEL_W-1:0]   conf_sel_a,
  output logic [PE_NUM*CONF_SEL_W-1:0]   conf_sel_b,
  output logic [PE_NUM*CONF_SE_W-1:0]    conf_se,
  output logic                           run_en,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWAP,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int ALU_T = PE_NUM * CONF_ALU_W;
  localparam int SEL_T = PE_NUM * CONF_SEL_W;
  localparam int SE_T  = PE_NUM * CONF_SE_W;

  // PE column limit widened by one bit so PE_NUM=16 still compares cleanly
  localparam logic [4:0] PE_LIM = 5'(PE_NUM);

  state_t state;
  state_t state_nx;

  logic [LEN_W-1:0] cnt;

  logic [ALU_T-1:0] sh_alu;
  logic [SEL_T-1:0] sh_sel_a;
  logic [SEL_T-1:0] sh_sel_b;
  logic [SE_T-1:0]  sh_se;

  logic wr_acc;
  logic wr_bad;
  logic wr_ok;
  logic start_acc;
  logic cnt_last;
  logic cnt_zero;

  assign cfg_ready = (state != ST_SWAP);
  assign run_en    = (state == ST_RUN);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  assign wr_acc    = cfg_valid && cfg_ready;
  assign wr_bad    = wr_acc && ({1'b0, cfg_pe} >= PE_LIM);
  assign wr_ok     = wr_acc && !wr_bad;

  // START is only honoured once the previous run has finished
  assign start_acc = start &&
                     ((state == ST_IDLE) || (state == ST_DONE));

  assign cnt_last  = (cnt == LEN_W'(1));
  assign cnt_zero  = (cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; ABORT outranks counter expiry in RUN
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (start_acc) begin
          state_nx = ST_SWAP;
        end
      end
      ST_SWAP: begin
        if (cnt_zero) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (cnt_last) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start_acc) begin
          state_nx = ST_SWAP;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Run-length counter: loaded on START, counts down through RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start_acc) begin
      cnt <= run_len;
    end else if (state == ST_RUN) begin
      if (abort) begin
        cnt <= '0;
      end else begin
        cnt <= cnt - LEN_W'(1);
      end
    end
  end

  // Shadow bank: legal writes land here in any ready state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_alu   <= '0;
      sh_sel_a <= '0;
      sh_sel_b <= '0;
      sh_se    <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < PE_NUM; i++) begin
        if (cfg_pe == 4'(i)) begin
          unique case (cfg_field)
            2'd0: sh_alu[i*CONF_ALU_W +: CONF_ALU_W] <=
                    cfg_data[CONF_ALU_W-1:0];
            2'd1: sh_sel_a[i*CONF_SEL_W +: CONF_SEL_W] <=
                    cfg_data[CONF_SEL_W-1:0];
            2'd2: sh_sel_b[i*CONF_SEL_W +: CONF_SEL_W] <=
                    cfg_data[CONF_SEL_W-1:0];
            2'd3: sh_se[i*CONF_SE_W +: CONF_SE_W] <=
                    cfg_data[CONF_SE_W-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Active bank: whole shadow copied at the closing edge of SWAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conf_alu   <= '0;
      conf_sel_a <= '0;
      conf_sel_b <= '0;
      conf_se    <= '0;
    end else if (state == ST_SWAP) begin
      conf_alu   <= sh_alu;
      conf_sel_a <= sh_sel_a;
      conf_sel_b <= sh_sel_b;
      conf_se    <= sh_se;
    end
  end

  // Sticky error: a bad write in the same edge as START keeps it set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (wr_bad) begin
      err <= 1'b1;
    end else if (start_acc) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_row_conf_ctrl.sv
// Directed testbench for row_conf_ctrl.
// Each task drives one scenario and checks its own expectations.
module tb_row_conf_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_pe;
  logic [1:0]  cfg_field;
  logic [3:0]  cfg_data;
  logic        start;
  logic [15:0] run_len;
  logic        abort;
  logic [47:0] conf_alu;
  logic [35:0] conf_sel_a;
  logic [35:0] conf_sel_b;
  logic [35:0] conf_se;
  logic        run_en;
  logic        busy;
  logic        done;
  logic        err;

  int checks;
  int failures;

  row_conf_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pe     (cfg_pe),
    .cfg_field  (cfg_field),
    .cfg_data   (cfg_data),
    .start      (start),
    .run_len    (run_len),
    .abort      (abort),
    .conf_alu   (conf_alu),
    .conf_sel_a (conf_sel_a),
    .conf_sel_b (conf_sel_b),
    .conf_se    (conf_se),
    .run_en     (run_en),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_pe = 4'd0;
    cfg_field = 2'd0;
    cfg_data = 4'd0;
    start = 1'b0;
    run_len = 16'd0;
    abort = 1'b0;
    #12;
    checks++;
    if ({run_en, busy, done, err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000",
               {run_en, busy, done, err});
    end
    checks++;
    if ({conf_alu, conf_sel_a, conf_sel_b, conf_se} !== '0) begin
      failures++;
      $display("FAIL reset_conf got=%h exp=0",
               {conf_alu, conf_sel_a, conf_sel_b, conf_se});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", cfg_ready);
    end
  endtask

  task automatic test_basic_run;
    cfg_valid = 1'b1;
    cfg_pe = 4'd3;
    cfg_field = 2'd0;
    cfg_data = 4'hA;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (conf_alu !== 48'h0) begin
      failures++;
      $display("FAIL basic_shadow_only got=%h exp=0", conf_alu);
    end
    start = 1'b1;
    run_len = 16'd5;
    tick();
    start = 1'b0;
    checks++;
    if ({cfg_ready, busy, run_en} !== 3'b010) begin
      failures++;
      $display("FAIL basic_swap got=%b exp=010",
               {cfg_ready, busy, run_en});
    end
    checks++;
    if (conf_alu !== 48'h0) begin
      failures++;
      $display("FAIL basic_swap_conf got=%h exp=0", conf_alu);
    end
    tick();
    checks++;
    if (run_en !== 1'b1) begin
      failures++;
      $display("FAIL basic_run_first got=%b exp=1", run_en);
    end
    checks++;
    if (conf_alu !== 48'h0000_0000_A000) begin
      failures++;
      $display("FAIL basic_conf_alu got=%h exp=a000", conf_alu);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({run_en, done} !== 2'b10) begin
        failures++;
        $display("FAIL basic_run_cycle%0d got=%b exp=10",
                 i + 2, {run_en, done});
      end
    end
    tick();
    checks++;
    if ({run_en, done} !== 2'b01) begin
      failures++;
      $display("FAIL basic_done got=%b exp=01", {run_en, done});
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL basic_idle got=%b exp=00", {busy, done});
    end
  endtask

  task automatic test_illegal_write;
    cfg_valid = 1'b1;
    cfg_pe = 4'd12;
    cfg_field = 2'd1;
    cfg_data = 4'd1;
    tick();
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL illegal_err_set got=%b exp=1", err);
    end
    cfg_pe = 4'd1;
    cfg_field = 2'd3;
    cfg_data = 4'd6;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL illegal_err_sticky got=%b exp=1", err);
    end
    start = 1'b1;
    run_len = 16'd0;
    tick();
    start = 1'b0;
    checks++;
    if ({err, cfg_ready} !== 2'b00) begin
      failures++;
      $display("FAIL zero_len_swap got=%b exp=00", {err, cfg_ready});
    end
    tick();
    checks++;
    if ({run_en, done} !== 2'b01) begin
      failures++;
      $display("FAIL zero_len_done got=%b exp=01", {run_en, done});
    end
    checks++;
    if (conf_se !== 36'h030) begin
      failures++;
      $display("FAIL zero_len_conf_se got=%h exp=030", conf_se);
    end
    checks++;
    if (conf_sel_a !== 36'h0) begin
      failures++;
      $display("FAIL illegal_dropped got=%h exp=0", conf_sel_a);
    end
    tick();
    checks++;
    if ({busy, run_en} !== 2'b00) begin
      failures++;
      $display("FAIL zero_len_idle got=%b exp=00", {busy, run_en});
    end
  endtask

  task automatic test_abort;
    start = 1'b1;
    run_len = 16'd10;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (run_en !== 1'b1) begin
      failures++;
      $display("FAIL abort_run1 got=%b exp=1", run_en);
    end
    cfg_valid = 1'b1;
    cfg_pe = 4'd0;
    cfg_field = 2'd3;
    cfg_data = 4'd5;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if ({run_en, conf_se} !== {1'b1, 36'h030}) begin
      failures++;
      $display("FAIL abort_run2 got=%b/%h exp=1/030", run_en, conf_se);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({run_en, done, busy} !== 3'b000) begin
      failures++;
      $display("FAIL abort_stop got=%b exp=000", {run_en, done, busy});
    end
    checks++;
    if (conf_se !== 36'h030) begin
      failures++;
      $display("FAIL abort_keep_se got=%h exp=030", conf_se);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done got=%b exp=0", done);
    end
    start = 1'b1;
    run_len = 16'd0;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (conf_se !== 36'h035) begin
      failures++;
      $display("FAIL abort_next_commit got=%h exp=035", conf_se);
    end
    tick();
  endtask

  task automatic test_start_in_run;
    start = 1'b1;
    run_len = 16'd3;
    tick();
    run_len = 16'd1;
    cfg_valid = 1'b1;
    cfg_pe = 4'd2;
    cfg_field = 2'd2;
    cfg_data = 4'd7;
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL sir_swap_ready got=%b exp=0", cfg_ready);
    end
    tick();
    checks++;
    if ({run_en, cfg_ready} !== 2'b11) begin
      failures++;
      $display("FAIL sir_run1 got=%b exp=11", {run_en, cfg_ready});
    end
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    checks++;
    if ({run_en, conf_sel_b} !== {1'b1, 36'h0}) begin
      failures++;
      $display("FAIL sir_run2 got=%b/%h exp=1/0", run_en, conf_sel_b);
    end
    tick();
    checks++;
    if (run_en !== 1'b1) begin
      failures++;
      $display("FAIL sir_run3 got=%b exp=1", run_en);
    end
    tick();
    checks++;
    if ({run_en, done} !== 2'b01) begin
      failures++;
      $display("FAIL sir_done got=%b exp=01", {run_en, done});
    end
    tick();
    start = 1'b1;
    run_len = 16'd0;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (conf_sel_b !== 36'h1C0) begin
      failures++;
      $display("FAIL sir_write_landed got=%h exp=1c0", conf_sel_b);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    start = 1'b1;
    run_len = 16'd0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    run_len = 16'd2;
    tick();
    start = 1'b0;
    checks++;
    if ({cfg_ready, busy, done} !== 3'b010) begin
      failures++;
      $display("FAIL b2b_swap got=%b exp=010",
               {cfg_ready, busy, done});
    end
    tick();
    checks++;
    if (run_en !== 1'b1) begin
      failures++;
      $display("FAIL b2b_run1 got=%b exp=1", run_en);
    end
    tick();
    checks++;
    if (run_en !== 1'b1) begin
      failures++;
      $display("FAIL b2b_run2 got=%b exp=1", run_en);
    end
    tick();
    checks++;
    if ({run_en, done} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_done got=%b exp=01", {run_en, done});
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_reset_mid_run;
    cfg_valid = 1'b1;
    cfg_pe = 4'd13;
    cfg_field = 2'd0;
    cfg_data = 4'd1;
    start = 1'b1;
    run_len = 16'd20;
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL rmr_set_wins got=%b exp=1", err);
    end
    tick();
    checks++;
    if (run_en !== 1'b1) begin
      failures++;
      $display("FAIL rmr_running got=%b exp=1", run_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({run_en, busy, done, err} !== 4'b0000) begin
      failures++;
      $display("FAIL rmr_async_flags got=%b exp=0000",
               {run_en, busy, done, err});
    end
    checks++;
    if ({conf_alu, conf_sel_a, conf_sel_b, conf_se} !== '0) begin
      failures++;
      $display("FAIL rmr_async_conf got=%h exp=0",
               {conf_alu, conf_sel_a, conf_sel_b, conf_se});
    end
    #3;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({cfg_ready, busy, done} !== 3'b100) begin
      failures++;
      $display("FAIL rmr_release got=%b exp=100",
               {cfg_ready, busy, done});
    end
    start = 1'b1;
    run_len = 16'd0;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if ({conf_alu, conf_sel_b, conf_se} !== '0) begin
      failures++;
      $display("FAIL rmr_shadow_cleared got=%h exp=0",
               {conf_alu, conf_sel_b, conf_se});
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic_run();
    test_illegal_write();
    test_abort();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/row_conf_ctrl.md
ROW_CONF_CTRL -- requirements
Module: row_conf_ctrl

Interface
REQ-001 SHALL have parameter PE_NUM, default 12, number of PE columns in one row.
REQ-002 SHALL have parameter CONF_ALU_W, default 4, ALU config bits per PE.
REQ-003 SHALL have parameter CONF_SEL_W, default 3, per-operand selector bits per PE.
REQ-004 SHALL have parameter CONF_SE_W, default 3, switch-element config bits per PE.
REQ-005 SHALL have parameter LEN_W, default 16, run-length counter width.
REQ-006 CLK  input  1  sole clock, rising edge.
REQ-007 RST_N  input  1  reset, asynchronous, active-low.
REQ-008 CFG_VALID  input  1  config-write request.
REQ-009 CFG_READY  output  1  config-write acceptance.
REQ-010 CFG_PE  input  4  target PE column.
REQ-011 CFG_FIELD  input  2  0=ALU, 1=SEL_A, 2=SEL_B, 3=SE.
REQ-012 CFG_DATA  input  4  field value, LSB-aligned, upper bits ignored for narrower fields.
REQ-013 START  input  1  commit shadow config and run.
REQ-014 RUN_LEN  input  LEN_W  run cycles, sampled on START acceptance.
REQ-015 ABORT  input  1  terminate run.
REQ-016 CONF_ALU  output  PE_NUM*CONF_ALU_W  active ALU config, PE n at bits [n*W +: W].
REQ-017 CONF_SEL_A, CONF_SEL_B  output  PE_NUM*CONF_SEL_W  active selector configs, same packing.
REQ-018 CONF_SE  output  PE_NUM*CONF_SE_W  active switch config, same packing.
REQ-019 RUN_EN  output  1  row datapath enable.
REQ-020 BUSY  output  1  high when state != IDLE.
REQ-021 DONE  output  1  one-cycle run-completion pulse.
REQ-022 ERR  output  1  sticky illegal-write flag.

Function
REQ-023 SHALL hold a shadow bank and an active bank of all four fields for every PE; only the active bank drives CONF_* outputs, all registered.
REQ-024 SHALL implement states IDLE, SWAP, RUN, DONE.
REQ-025 SHALL drive CFG_READY=1 in IDLE, RUN, DONE and 0 in SWAP.
REQ-026 SHALL write CFG_DATA into shadow[CFG_PE][CFG_FIELD] on a clock edge with CFG_VALID&&CFG_READY; active bank unaffected.
REQ-027 SHALL drop an accepted write with CFG_PE>=PE_NUM and set ERR at that edge.
REQ-028 SHALL accept START only in IDLE or DONE; START in SWAP or RUN ignored.
REQ-029 On accepted START: next state SWAP, RUN_LEN latched, ERR cleared unless an illegal write is accepted the same edge (set wins).
REQ-030 A shadow write accepted at the same edge as START SHALL be included in the committed config.
REQ-031 SWAP lasts one cycle; at its closing edge active<=shadow; next state RUN if latched length>0, else DONE.
REQ-032 RUN_EN SHALL be 1 exactly in RUN, for exactly latched RUN_LEN cycles (down-counter), then DONE.
REQ-033 Latency: START sampled at edge k -> SWAP in cycle k+1 -> new CONF_* and RUN_EN=1 from cycle k+2.
REQ-034 DONE state lasts one cycle with DONE=1, then IDLE (or SWAP if START accepted there).
REQ-035 ABORT in RUN SHALL move to IDLE at next edge, no DONE pulse, active config retained; ABORT elsewhere ignored; ABORT wins over counter expiry at the same edge.
REQ-036 Shadow writes during RUN SHALL not disturb outputs until the next SWAP.

Reset
REQ-037 RST_N low SHALL immediately force state IDLE, both banks and all CONF_* to 0, RUN_EN=0, DONE=0, ERR=0, counter 0, CFG_READY=1 after release.
REQ-038 Reset asserted mid-RUN SHALL drop RUN_EN asynchronously with no DONE pulse.

Verification
REQ-039 Write PE3 ALU=0xA (masked to 4 bits), START RUN_LEN=5 -> CONF_ALU[15:12]=0xA from cycle k+2, RUN_EN high 5 cycles, DONE pulse in cycle k+7.
REQ-040 Write PE12 SEL_A=1 -> CONF_* unchanged, ERR=1; subsequent START clears ERR.
REQ-041 START RUN_LEN=0 -> SWAP then DONE, RUN_EN never high, config committed.
REQ-042 During RUN write PE0 SE=5, ABORT at run cycle 2 -> RUN_EN low next cycle, no DONE, CONF_SE[2:0] keeps old value until next START.
REQ-043 START during RUN and CFG_VALID during SWAP -> START ignored, CFG_READY=0 stalls write one cycle, write completes in RUN.
REQ-044 Assert RST_N low mid-RUN -> all outputs 0 asynchronously, CFG_READY=1 after release.
